// File: rtl/pdh_cmd_master.sv
// Command-word sender for the pdh_core GPIO protocol: setup, strobe, and release, then callback sampling.
// Optional macro PDH_CMD_VERIFY_EN adds a readback compare to rsp_err_o.
module pdh_cmd_master #(
  parameter int AXI_GPIO_WIDTH = 32,
  parameter int SETUP_CYCLES   = 2,
  parameter int RESP_LATENCY   = 6,
  parameter int RST_CYCLES     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [3:0]                cmd_i,
  input  logic [25:0]               data_i,
  input  logic                      core_rst_req_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [AXI_GPIO_WIDTH-1:0] rsp_data_o,
  output logic                      rsp_err_o,
  output logic                      busy_o,
  output logic [AXI_GPIO_WIDTH-1:0] axi_to_core_o,
  input  logic [AXI_GPIO_WIDTH-1:0] axi_from_core_i
);

  localparam int W = AXI_GPIO_WIDTH;

  typedef enum logic [2:0] {IDLE, CORE_RST, SETUP, STROBE, RESP} state_t;

  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [W-1:0]  word_q, word_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [W-1:0]  rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;

  function automatic logic status_err(input logic [W-1:0] cb, input logic [3:0] cmd);
    logic [3:0] exp_nib;
    exp_nib = (cmd == 4'd1 || cmd == 4'd2) ? 4'h1 : 4'h0;
    return cb[31:28] != exp_nib;
  endfunction

`ifdef PDH_CMD_VERIFY_EN
  function automatic logic readback_err(input logic [W-1:0] cb, input logic [3:0] cmd,
                                        input logic [25:0] data);
    logic e;
    e = 1'b0;
    case (cmd)
      4'd1:    e = cb[7:0] != data[7:0];
      4'd2:    e = data[14] ? (cb[27:14] != data[13:0]) : (cb[13:0] != data[13:0]);
      default: e = 1'b0;
    endcase
    return e;
  endfunction

  function automatic logic resp_err(input logic [W-1:0] cb, input logic [3:0] cmd,
                                    input logic [25:0] data);
    return status_err(cb, cmd) | readback_err(cb, cmd, data);
  endfunction
`else
  function automatic logic resp_err(input logic [W-1:0] cb, input logic [3:0] cmd,
                                    input logic [25:0] data);
    logic unused;
    unused = ^data;
    return status_err(cb, cmd);
  endfunction
`endif

  // Reset request wins over a same-cycle command, so ready must drop with it.
  assign cmd_ready_o = (state_q == IDLE) && !core_rst_req_i && !rst;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (core_rst_req_i) begin
          state_d       = CORE_RST;
          cnt_d         = 16'(RST_CYCLES - 1);
          word_d        = '0;
          word_d[W-1]   = 1'b1;
        end else if (cmd_valid_i) begin
          state_d = SETUP;
          cnt_d   = 16'(SETUP_CYCLES - 1);
          word_d  = W'({2'b00, cmd_i, data_i});
        end
      end
      CORE_RST: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          word_d  = '0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d     = STROBE;
          cnt_d       = 16'(RESP_LATENCY - 1);
          word_d[W-2] = 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STROBE: begin
        // Last strobe cycle: capture callback and release strobe; cmd/data stay on the bus.
        if (cnt_q == '0) begin
          state_d     = RESP;
          word_d[W-2] = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = axi_from_core_i;
          rsp_err_d   = resp_err(axi_from_core_i, word_q[29:26], word_q[25:0]);
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      word_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_o      <= (state_d != IDLE);
    end
  end

  assign axi_to_core_o = word_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign rsp_err_o     = rsp_err_q;

endmodule

// File: tb/tb_pdh_cmd_master.sv
// Bench for pdh_cmd_master: table of commands against a behavioural core model, plus
// hand-written reset, backpressure and core-reset sequences.
module tb_pdh_cmd_master;

`ifdef PDH_CMD_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready_o;
  logic [3:0]  cmd_in;
  logic [25:0] data_in;
  logic        core_rst_req;
  logic        rsp_valid_o;
  logic        rsp_ready;
  logic [31:0] rsp_data_o;
  logic        rsp_err_o;
  logic        busy_o;
  logic [31:0] axi_to_core_o;
  logic [31:0] from_core;

  pdh_cmd_master dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid_i    (cmd_valid),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_i          (cmd_in),
    .data_i         (data_in),
    .core_rst_req_i (core_rst_req),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready),
    .rsp_data_o     (rsp_data_o),
    .rsp_err_o      (rsp_err_o),
    .busy_o         (busy_o),
    .axi_to_core_o  (axi_to_core_o),
    .axi_from_core_i(from_core)
  );

  always #5 clk = ~clk;

  // Core model: latch the callback on each rising strobe edge.
  logic        stub_en;
  logic [31:0] stub_val;
  logic [31:0] cb_reg = 32'h0;
  logic        prev_strobe = 1'b0;

  function automatic logic [31:0] core_cb(input logic [31:0] w);
    logic [25:0] d;
    d = w[25:0];
    case (w[29:26])
      4'd1:    return {4'h1, 20'h0, d[7:0]};
      4'd2:    return d[14] ? {4'h1, d[13:0], 14'h0} : {4'h1, 14'h0, d[13:0]};
      default: return 32'h0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (axi_to_core_o[30] && !prev_strobe) cb_reg <= core_cb(axi_to_core_o);
    prev_strobe <= axi_to_core_o[30];
  end

  assign from_core = stub_en ? stub_val : cb_reg;

  typedef struct {
    logic [3:0]  cmd;
    logic [25:0] data;
    bit          stub;
    logic [31:0] stub_val;
    logic [31:0] exp_data;
    bit          exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] c, input logic [25:0] d);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_in = c; data_in = d;
    #1;
    while (!cmd_ready_o && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chk("accept_wait", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Entered one step after the accepting edge (accept+1).
  task automatic run_resp(input logic [3:0] c, input logic [25:0] d);
    logic [31:0] sw;
    int k, t_strobe, edges;
    logic prev;
    exp_t e;
    sw = {2'b00, c, d};
    k = 1; t_strobe = -1; edges = 0; prev = 1'b0;
    chk("setup_word", axi_to_core_o, sw);
    chk("busy", 32'(busy_o), 32'd1);
    while (k <= 20) begin
      if (axi_to_core_o[30] && !prev) begin
        edges++;
        if (t_strobe < 0) t_strobe = k;
      end
      prev = axi_to_core_o[30];
      if (rsp_valid_o) break;
      @(posedge clk); #1; k++;
    end
    chk("strobe_rise_cycle", 32'(t_strobe), 32'd3);
    chk("rsp_latency", 32'(k), 32'd9);
    chk("strobe_edges", 32'(edges), 32'd1);
    chk("release_word", axi_to_core_o, sw);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("rsp_data", rsp_data_o, e.d);
      chk("rsp_err", 32'(rsp_err_o), 32'(e.e));
    end
    if (rsp_ready) begin
      @(posedge clk); #1;
      chk("rsp_one_cycle", 32'(rsp_valid_o), 32'd0);
      chk("idle_busy", 32'(busy_o), 32'd0);
      chk("idle_word_hold", axi_to_core_o, sw);
    end
  endtask

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall_bad, hi, bad, n;
    logic [31:0] saved;

    vecs[0] = '{4'd1, 26'h00000A5, 1'b0, 32'h0,         32'h1000_00A5, 1'b0};
    vecs[1] = '{4'd2, 26'h0005234, 1'b0, 32'h0,         32'h148D_0000, 1'b0};
    vecs[2] = '{4'd2, 26'h0000ABC, 1'b0, 32'h0,         32'h1000_0ABC, 1'b0};
    vecs[3] = '{4'd0, 26'h3FFFFFF, 1'b0, 32'h0,         32'h0000_0000, 1'b0};
    vecs[4] = '{4'd5, 26'h0000123, 1'b0, 32'h0,         32'h0000_0000, 1'b0};
    vecs[5] = '{4'd1, 26'h00000A5, 1'b1, 32'h0,         32'h0000_0000, 1'b1};
    vecs[6] = '{4'd1, 26'h000015A, 1'b1, 32'h1000_0000, 32'h1000_0000, VERIFY};
    vecs[7] = '{4'd2, 26'h0001234, 1'b1, 32'h0000_1234, 32'h0000_1234, 1'b1};

    rst = 1'b1; cmd_valid = 1'b0; cmd_in = '0; data_in = '0;
    core_rst_req = 1'b0; rsp_ready = 1'b1; stub_en = 1'b0; stub_val = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_word", axi_to_core_o, 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_ready_low", 32'(cmd_ready_o), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_ready_after", 32'(cmd_ready_o), 32'd1);

    for (int i = 0; i < 8; i++) begin
      stub_en = vecs[i].stub; stub_val = vecs[i].stub_val;
      sb.push_back('{vecs[i].exp_data, vecs[i].exp_err});
      issue(vecs[i].cmd, vecs[i].data);
      run_resp(vecs[i].cmd, vecs[i].data);
    end
    stub_en = 1'b0;

    // Reset in the middle of the strobe window.
    issue(4'd1, 26'h00000A5);
    repeat (4) begin @(posedge clk); #1; end
    chk("mr_in_strobe", 32'(axi_to_core_o[30]), 32'd1);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mr_word", axi_to_core_o, 32'h0);
    chk("mr_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("mr_busy", 32'(busy_o), 32'd0);
    rst = 1'b0;
    #1;
    chk("mr_ready", 32'(cmd_ready_o), 32'd1);
    @(posedge clk); #1;
    chk("mr_word_after", axi_to_core_o, 32'h0);
    chk("mr_rsp_after", 32'(rsp_valid_o), 32'd0);

    // Backpressure: response held, next command stalled.
    rsp_ready = 1'b0;
    sb.push_back('{32'h1000_00A5, 1'b0});
    issue(4'd1, 26'h00000A5);
    run_resp(4'd1, 26'h00000A5);
    saved = rsp_data_o;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_in = 4'd2; data_in = 26'h0000ABC;
    stall_bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (!rsp_valid_o || rsp_data_o !== saved || rsp_err_o !== 1'b0 || cmd_ready_o)
        stall_bad++;
    end
    chk("bp_stall", 32'(stall_bad), 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_consumed", 32'(rsp_valid_o), 32'd0);
    chk("bp_ready", 32'(cmd_ready_o), 32'd1);
    sb.push_back('{32'h1000_0ABC, 1'b0});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    run_resp(4'd2, 26'h0000ABC);

    // Core reset request colliding with a command.
    @(negedge clk);
    core_rst_req = 1'b1; cmd_valid = 1'b1; cmd_in = 4'd1; data_in = 26'h000003C;
    #1;
    chk("cr_ready_blocked", 32'(cmd_ready_o), 32'd0);
    @(posedge clk); #1;
    core_rst_req = 1'b0;
    chk("cr_word", axi_to_core_o, 32'h8000_0000);
    hi = 1; bad = 0; n = 0;
    while (axi_to_core_o[31] && n < 20) begin
      if (cmd_ready_o) bad++;
      @(posedge clk); #1; n++;
      if (axi_to_core_o[31]) hi++;
    end
    chk("cr_len", 32'(hi), 32'd4);
    chk("cr_no_accept", 32'(bad), 32'd0);
    chk("cr_word_clear", axi_to_core_o, 32'h0);
    chk("cr_ready_after", 32'(cmd_ready_o), 32'd1);
    sb.push_back('{32'h1000_003C, 1'b0});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    run_resp(4'd1, 26'h000003C);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
